alu_share_ctrl: RTL and testbench
=================================

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter: PRIO_INIT, default 0, index of the requester holding priority after reset.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 rN_ready  output  1  requester N operation accepted this cycle.
REQ-006 rN_op  input  4  ALU opcode (0000..1001 legal).
REQ-007 rN_a, rN_b  input  32 each  operands.
REQ-008 rN_rvalid  output  1  result slot N holds a result.
REQ-009 rN_rready  input  1  requester N consumes the result.
REQ-010 rN_result  output  32  registered result.
REQ-011 rN_zero  output  1  registered zero flag.
REQ-012 rN_err  output  1  registered illegal-opcode flag.
REQ-013 alu_op  output  4  opcode to the shared ALU.
REQ-014 alu_a, alu_b  output  32 each  operands to the shared ALU.
REQ-015 alu_out  input  32  combinational ALU result.
REQ-016 alu_zero  input  1  combinational ALU zero flag.

Function
REQ-017 The block SHALL share one combinational ALU between two requesters, issuing at most one operation per cycle.
REQ-018 Each requester SHALL own a one-entry result slot, states EMPTY and FULL.
REQ-019 Requester N is eligible when rN_valid=1 and slot N is EMPTY, or FULL with rN_rready=1 (same-cycle drain-and-refill).
REQ-020 If one requester is eligible it SHALL be granted; if both, the one holding priority SHALL be granted.
REQ-021 Priority SHALL toggle to the other requester only on a grant to the current priority holder (round-robin).
REQ-022 rN_ready SHALL be combinational and equal to grant N; at most one rN_ready high per cycle.
REQ-023 alu_op/alu_a/alu_b SHALL mux the granted requester's fields; with no grant they SHALL drive 0.
REQ-024 On grant in cycle T, slot N SHALL capture alu_out and alu_zero at the edge ending T; rN_rvalid=1 from T+1 (latency 1).
REQ-025 rN_err SHALL be captured as 1 when the granted opcode is 1010..1111, with result 0 and zero 1 as the ALU returns.
REQ-026 Slot N SHALL go FULL->EMPTY when rN_rvalid=1 and rN_rready=1 without a new grant; result fields hold their values while FULL and not drained.
REQ-027 rN_result/rN_zero/rN_err SHALL be stable while rN_rvalid=1 and rN_rready=0.
REQ-028 rN_rready while EMPTY SHALL have no effect.
REQ-029 A requester whose slot is FULL and not draining SHALL NOT be granted; the other requester is granted if eligible (no head-of-line blocking).

Reset
REQ-030 rst_n=0 SHALL immediately clear both slots to EMPTY, rN_rvalid/rN_result/rN_zero/rN_err to 0, and priority to PRIO_INIT.
REQ-031 An operation granted in the cycle reset asserts SHALL be discarded; no result appears after release.
REQ-032 While rst_n=0, rN_ready SHALL be 0.

Structure
REQ-033 Opcode constants (AND..SRA, 0000..1001) and OP_MAX_LEGAL SHALL live in the shared ALU package, used by this block and the ALU.
REQ-034 Round-robin grant logic SHALL be one sub-module, rr_arb2 (inputs elig[1:0], outputs gnt[1:0], internal priority flop).
REQ-035 The ALU SHALL be instantiated outside this block.

Verification
REQ-036 Only r0 valid, op 0010, a=5, b=7 -> r0_ready=1 cycle T, r0_rvalid=1 cycle T+1, r0_result=12, r0_zero=0.
REQ-037 Both valid every cycle, both rready=1, PRIO_INIT=0 -> grants r0,r1,r0,r1; alu_op alternates between the two opcodes.
REQ-038 r0 slot FULL, r0_rready=0, both valid -> r1 granted each cycle; r0_result held unchanged; after r0_rready=1 r0 regains grant per priority.
REQ-039 r1 op 0110, a=9, b=9 -> r1_result=0, r1_zero=1, r1_err=0; r1 op 1100 -> r1_err=1, r1_result=0.
REQ-040 r0 op 1000, a=32'hFFFF_FFFF, b=1 -> r0_result=1; op 0111 same operands -> r0_result=0.
REQ-041 rst_n low mid-stream with both slots FULL -> all rvalid 0 immediately, priority=PRIO_INIT, no result after release.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared ALU definitions: opcode encodings, legal-opcode bound and result
// slot states. Imported by the sharing controller and by the ALU itself.
package alu_share_ctrl_pkg;

  // ALU opcodes. Encodings 1010..1111 are illegal; the ALU returns 0 for them.
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,  // a & b
    OP_OR   = 4'b0001,  // a | b
    OP_ADD  = 4'b0010,  // a + b
    OP_XOR  = 4'b0011,  // a ^ b
    OP_SLL  = 4'b0100,  // a << b[4:0]
    OP_SRL  = 4'b0101,  // a >> b[4:0], logical
    OP_SUB  = 4'b0110,  // a - b
    OP_SLTU = 4'b0111,  // a < b, unsigned compare
    OP_SLT  = 4'b1000,  // a < b, signed compare
    OP_SRA  = 4'b1001   // a >>> b[4:0], arithmetic
  } alu_op_e;

  localparam logic [3:0] OP_MAX_LEGAL = OP_SRA;

  // One-entry result slot per requester.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_MAX_LEGAL);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// Two-way round-robin arbiter. The priority holder wins a tie; priority
// moves to the other side only when the holder itself is granted.
module rr_arb2 #(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  output logic [1:0] gnt
);

  localparam logic PRIO_RST = 1'(PRIO_INIT);

  logic prio;

  // Grant the lone eligible requester, or the priority holder on a tie.
  always_comb begin
    gnt = '0;
    if (elig[0] && elig[1]) begin
      gnt[prio] = 1'b1;
    end else begin
      gnt = elig;
    end
  end

  // Toggle priority only when the current holder is served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO_RST;
    end else if (gnt[prio]) begin
      prio <= ~prio;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters. Each
// requester owns a one-entry result slot that captures the ALU output one
// cycle after its grant; a full slot may drain and refill in the same cycle.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [3:0]  r0_op,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  output logic        r0_rvalid,
  input  logic        r0_rready,
  output logic [31:0] r0_result,
  output logic        r0_zero,
  output logic        r0_err,
  // requester 1
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [3:0]  r1_op,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        r1_rvalid,
  input  logic        r1_rready,
  output logic [31:0] r1_result,
  output logic        r1_zero,
  output logic        r1_err,
  // shared ALU
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero
);

  slot_state_e s0_state, s1_state;
  logic [1:0]  elig, gnt;

  // A requester is eligible when its slot is empty or draining this cycle;
  // reset masks eligibility so no ready is raised while rst_n is low.
  always_comb begin
    elig    = '0;
    elig[0] = rst_n & r0_valid & ((s0_state == SLOT_EMPTY) | r0_rready);
    elig[1] = rst_n & r1_valid & ((s1_state == SLOT_EMPTY) | r1_rready);
  end

  rr_arb2 #(
    .PRIO_INIT (PRIO_INIT)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .elig  (elig),
    .gnt   (gnt)
  );

  assign r0_ready  = gnt[0];
  assign r1_ready  = gnt[1];
  assign r0_rvalid = (s0_state == SLOT_FULL);
  assign r1_rvalid = (s1_state == SLOT_FULL);

  // Route the granted requester's operation to the ALU; idle drives zero.
  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (gnt[0]) begin
      alu_op = r0_op;
      alu_a  = r0_a;
      alu_b  = r0_b;
    end else if (gnt[1]) begin
      alu_op = r1_op;
      alu_a  = r1_a;
      alu_b  = r1_b;
    end
  end

  // Slot 0: capture on grant (covers drain-and-refill), else drain on rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_state  <= SLOT_EMPTY;
      r0_result <= '0;
      r0_zero   <= 1'b0;
      r0_err    <= 1'b0;
    end else if (gnt[0]) begin
      s0_state  <= SLOT_FULL;
      r0_result <= alu_out;
      r0_zero   <= alu_zero;
      r0_err    <= op_illegal(r0_op);
    end else if ((s0_state == SLOT_FULL) && r0_rready) begin
      s0_state  <= SLOT_EMPTY;
    end
  end

  // Slot 1: capture on grant (covers drain-and-refill), else drain on rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_state  <= SLOT_EMPTY;
      r1_result <= '0;
      r1_zero   <= 1'b0;
      r1_err    <= 1'b0;
    end else if (gnt[1]) begin
      s1_state  <= SLOT_FULL;
      r1_result <= alu_out;
      r1_zero   <= alu_zero;
      r1_err    <= op_illegal(r1_op);
    end else if ((s1_state == SLOT_FULL) && r1_rready) begin
      s1_state  <= SLOT_EMPTY;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: plays the external ALU, applies a table of
// single-requester operations, then hand-written arbitration and reset runs.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_rvalid, r0_rready, r0_zero, r0_err;
  logic [3:0]  r0_op;
  logic [31:0] r0_a, r0_b, r0_result;
  logic        r1_valid, r1_ready, r1_rvalid, r1_rready, r1_zero, r1_err;
  logic [3:0]  r1_op;
  logic [31:0] r1_a, r1_b, r1_result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.PRIO_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_result(r0_result),
    .r0_zero(r0_zero), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_result(r1_result),
    .r1_zero(r1_zero), .r1_err(r1_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // External ALU model.
  always_comb begin
    case (alu_op)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd3:    alu_out = alu_a ^ alu_b;
      4'd4:    alu_out = alu_a << alu_b[4:0];
      4'd5:    alu_out = alu_a >> alu_b[4:0];
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = {31'd0, (alu_a < alu_b)};
      4'd8:    alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      4'd9:    alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  typedef struct {
    logic        req;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  logic        got_rdy, oth_rdy, got_rv, got_z, got_e;
  logic [31:0] got_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_valid = 1'b0; r0_rready = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0;
    r1_valid = 1'b0; r1_rready = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, OP_ADD,  32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    vecs[1]  = '{1'b0, OP_AND,  32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, OP_OR,   32'd1,          32'd2,          32'd3,          1'b0, 1'b0};
    vecs[3]  = '{1'b0, OP_XOR,  32'hAAAA_5555,  32'hAAAA_5555,  32'd0,          1'b1, 1'b0};
    vecs[4]  = '{1'b0, OP_SLL,  32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, OP_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, OP_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0};
    vecs[7]  = '{1'b0, OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
    vecs[8]  = '{1'b0, OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
    vecs[9]  = '{1'b0, OP_ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
    vecs[10] = '{1'b1, OP_SUB,  32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'b1100, 32'd5,          32'd3,          32'd0,          1'b1, 1'b1};
    vecs[12] = '{1'b1, 4'b1111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b1};
    vecs[13] = '{1'b1, OP_SUB,  32'd10,         32'd3,          32'd7,          1'b0, 1'b0};

    // Reset with both requesters presenting: no ready, slots empty.
    idle();
    rst_n = 1'b0;
    r0_valid = 1'b1; r0_op = OP_ADD;
    r1_valid = 1'b1; r1_op = OP_SUB;
    #3;
    chk("rst_r0_ready", 32'(r0_ready), 32'd0);
    chk("rst_r1_ready", 32'(r1_ready), 32'd0);
    chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("rst_r0_result", r0_result, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    do_reset();

    // rready while empty does nothing.
    r0_rready = 1'b1; r1_rready = 1'b1;
    step();
    chk("empty_rready_r0", 32'(r0_rvalid), 32'd0);
    chk("empty_rready_r1", 32'(r1_rvalid), 32'd0);
    idle();

    // Table of single-requester operations.
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].req) begin
        r1_valid = 1'b1; r1_op = vecs[i].op; r1_a = vecs[i].a; r1_b = vecs[i].b;
      end else begin
        r0_valid = 1'b1; r0_op = vecs[i].op; r0_a = vecs[i].a; r0_b = vecs[i].b;
      end
      #2;
      got_rdy = vecs[i].req ? r1_ready : r0_ready;
      oth_rdy = vecs[i].req ? r0_ready : r1_ready;
      chk($sformatf("vec%0d_ready", i), 32'(got_rdy), 32'd1);
      chk($sformatf("vec%0d_other_ready", i), 32'(oth_rdy), 32'd0);
      chk($sformatf("vec%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].op));
      chk($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].a);
      step();
      idle();
      #1;
      got_rv  = vecs[i].req ? r1_rvalid : r0_rvalid;
      got_res = vecs[i].req ? r1_result : r0_result;
      got_z   = vecs[i].req ? r1_zero   : r0_zero;
      got_e   = vecs[i].req ? r1_err    : r0_err;
      chk($sformatf("vec%0d_rvalid", i), 32'(got_rv), 32'd1);
      chk($sformatf("vec%0d_result", i), got_res, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), 32'(got_z), 32'(vecs[i].zero));
      chk($sformatf("vec%0d_err", i), 32'(got_e), 32'(vecs[i].err));
      chk($sformatf("vec%0d_idle_alu_op", i), 32'(alu_op), 32'd0);
      if (vecs[i].req) r1_rready = 1'b1; else r0_rready = 1'b1;
      step();
      got_rv = vecs[i].req ? r1_rvalid : r0_rvalid;
      chk($sformatf("vec%0d_drained", i), 32'(got_rv), 32'd0);
      idle();
    end

    // Round-robin with both requesters always valid and draining.
    do_reset();
    r0_valid = 1'b1; r0_op = OP_ADD; r0_a = 32'd1;  r0_b = 32'd2; r0_rready = 1'b1;
    r1_valid = 1'b1; r1_op = OP_SUB; r1_a = 32'd10; r1_b = 32'd4; r1_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("rr%0d_r0_ready", k), 32'(r0_ready), 32'((k % 2) == 0));
      chk($sformatf("rr%0d_r1_ready", k), 32'(r1_ready), 32'((k % 2) == 1));
      chk($sformatf("rr%0d_alu_op", k), 32'(alu_op), ((k % 2) == 0) ? 32'(OP_ADD) : 32'(OP_SUB));
      step();
      if ((k % 2) == 0) begin
        chk($sformatf("rr%0d_r0_rvalid", k), 32'(r0_rvalid), 32'd1);
        chk($sformatf("rr%0d_r0_result", k), r0_result, 32'd3);
      end else begin
        chk($sformatf("rr%0d_r1_rvalid", k), 32'(r1_rvalid), 32'd1);
        chk($sformatf("rr%0d_r1_result", k), r1_result, 32'd6);
      end
    end
    chk("rr_end_r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rr_end_r1_rvalid", 32'(r1_rvalid), 32'd1);

    // r0 slot held full: r1 served every cycle, r0 result stable.
    do_reset();
    r0_valid = 1'b1; r0_op = OP_ADD; r0_a = 32'd5; r0_b = 32'd7;
    #2;
    chk("hol_first_r0_ready", 32'(r0_ready), 32'd1);
    step();
    chk("hol_first_r0_result", r0_result, 32'd12);
    r0_op = OP_OR; r0_a = 32'h0000_00F0; r0_b = 32'h0000_000F;
    r1_valid = 1'b1; r1_op = OP_XOR; r1_b = 32'd0; r1_rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r1_a = 32'h100 + 32'(k);
      #2;
      chk($sformatf("hol%0d_r0_ready", k), 32'(r0_ready), 32'd0);
      chk($sformatf("hol%0d_r1_ready", k), 32'(r1_ready), 32'd1);
      step();
      chk($sformatf("hol%0d_r0_result", k), r0_result, 32'd12);
      chk($sformatf("hol%0d_r0_rvalid", k), 32'(r0_rvalid), 32'd1);
      chk($sformatf("hol%0d_r1_result", k), r1_result, 32'h100 + 32'(k));
    end
    r0_rready = 1'b1;
    #2;
    chk("hol_release_r0_ready", 32'(r0_ready), 32'd1);
    chk("hol_release_r1_ready", 32'(r1_ready), 32'd0);
    step();
    chk("hol_release_r0_result", r0_result, 32'h0000_00FF);
    #2;
    chk("hol_next_r1_ready", 32'(r1_ready), 32'd1);
    step();
    r1_rready = 1'b0;
    #2;
    chk("hol_last_r0_ready", 32'(r0_ready), 32'd1);
    step();
    chk("full_r0_rvalid", 32'(r0_rvalid), 32'd1);
    chk("full_r1_rvalid", 32'(r1_rvalid), 32'd1);

    // Reset mid-stream with both slots full and a grant in flight.
    r0_rready = 1'b1; r1_rready = 1'b1;
    #1;
    chk("midrst_pre_r1_ready", 32'(r1_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("midrst_r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("midrst_r0_result", r0_result, 32'd0);
    chk("midrst_r1_result", r1_result, 32'd0);
    chk("midrst_r0_ready", 32'(r0_ready), 32'd0);
    chk("midrst_r1_ready", 32'(r1_ready), 32'd0);
    step();
    step();
    idle();
    rst_n = 1'b1;
    step();
    chk("postrst_r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("postrst_r1_rvalid", 32'(r1_rvalid), 32'd0);
    r0_valid = 1'b1; r0_op = OP_ADD;
    r1_valid = 1'b1; r1_op = OP_SUB;
    #2;
    chk("postrst_prio_r0_ready", 32'(r0_ready), 32'd1);
    chk("postrst_prio_r1_ready", 32'(r1_ready), 32'd0);
    step();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
